// File: rtl/axi4lite_write_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_write_ctrl_pkg
//
// Shared definitions for the AXI4-Lite slave register-access path.
// Holds the B/R response codes, the write-controller state encoding and the
// address-to-word shift helper used by both the write path and the read path.
//
// Contents:
//   RESP_OKAY, RESP_SLVERR  AXI response codes (2 bits)
//   wr_state_e              write-controller state encoding
//   addr_lsb()              number of low address bits covered by one data
//                           word, as a function of the data bus width
// -----------------------------------------------------------------------------
package axi4lite_write_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Encoding is fixed so that debug dumps and checkers can decode the
    // exported state without referring back to this package.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } wr_state_e;

    // One register occupies DATA_WIDTH/8 bytes of address space, so the
    // word address is the byte address shifted right by log2(bytes/word).
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4lite_addr_decode.sv
// -----------------------------------------------------------------------------
// axi4lite_addr_decode
//
// Purely combinational byte-address decoder shared by the AXI4-Lite write and
// read controllers. The byte address is reduced to a word address; the low
// bits of that word select the register and the whole word is range-checked
// against the number of implemented registers. Sub-word address bits are
// ignored, so unaligned addresses are not an error.
//
// Ports:
//   addr      in   ADDR_WIDTH  byte address
//   index     out  IDX_WIDTH   register index (low bits of the word address)
//   in_range  out  1           word address selects an implemented register
// -----------------------------------------------------------------------------
module axi4lite_addr_decode
    import axi4lite_write_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [IDX_WIDTH-1:0]  index,
    output logic                  in_range
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] word;

    assign word  = addr >> ADDR_LSB;
    assign index = word[IDX_WIDTH-1:0];

    // Comparing the full word catches both nonzero upper bits and indices
    // past the last register when NUM_REGS is not a power of two.
    assign in_range = (word < ADDR_WIDTH'(NUM_REGS));

endmodule

// File: rtl/axi4lite_write_ctrl.sv
// -----------------------------------------------------------------------------
// axi4lite_write_ctrl
//
// AXI4-Lite slave write-path controller. Sits behind the AW and W skid
// buffers, joins one AW beat with one W beat into a single register-file
// write and returns a B response. Only one transaction is in flight at a
// time: IDLE -> WRITE -> RESP -> IDLE, or IDLE -> RESP directly when the
// address decodes outside the register file (SLVERR, no register write).
//
// Handshake rules (all channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. Once asserted, the controller's own
// valids (reg_wr_en, b_valid) and their payloads stay stable until accepted.
// AW and W are accepted only together, in IDLE, so one channel is never
// consumed without the other.
//
// Ports:
//   clk           in   1             clock, rising edge
//   resetn        in   1             asynchronous reset, active low
//   aw_valid      in   1             write-address valid
//   aw_ready      out  1             write-address ready (combinational)
//   aw_addr       in   ADDR_WIDTH    byte address
//   w_valid       in   1             write-data valid
//   w_ready       out  1             write-data ready (combinational)
//   w_data        in   DATA_WIDTH    write data
//   w_strb        in   DATA_WIDTH/8  byte strobes
//   reg_wr_en     out  1             register-file write request
//   reg_wr_ready  in   1             register file accepts the write
//   reg_wr_index  out  IDX_WIDTH     register index
//   reg_wr_data   out  DATA_WIDTH    latched write data
//   reg_wr_strb   out  DATA_WIDTH/8  latched strobes
//   b_valid       out  1             write-response valid
//   b_ready       in   1             write-response ready
//   b_resp        out  2             00 OKAY, 10 SLVERR
//   dbg_state     out  2             current FSM state (wr_state_e encoding)
// -----------------------------------------------------------------------------
module axi4lite_write_ctrl
    import axi4lite_write_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,

    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,

    output logic                    reg_wr_en,
    input  logic                    reg_wr_ready,
    output logic [IDX_WIDTH-1:0]    reg_wr_index,
    output logic [DATA_WIDTH-1:0]   reg_wr_data,
    output logic [DATA_WIDTH/8-1:0] reg_wr_strb,

    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [1:0]              b_resp,

    output logic [1:0]              dbg_state
);

    wr_state_e              state_q;
    wr_state_e              state_d;
    logic                   accept;
    logic [IDX_WIDTH-1:0]   dec_index;
    logic                   dec_in_range;

    axi4lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_addr_decode (
        .addr     (aw_addr),
        .index    (dec_index),
        .in_range (dec_in_range)
    );

    // Next-state logic. `accept` is the joint AW+W handshake and is also
    // what drives both ready outputs, so the readies can only rise together
    // and only while both valids are present.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept = aw_valid & w_valid;
                if (accept) begin
                    state_d = dec_in_range ? ST_WRITE : ST_RESP;
                end
            end
            ST_WRITE: begin
                if (reg_wr_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign aw_ready  = accept;
    assign w_ready   = accept;
    assign dbg_state = state_q;

    // State register plus registered outputs. The request/response valids
    // are decoded from the next state so they are true flops that line up
    // exactly with the state they belong to; since WRITE and RESP are
    // distinct states, reg_wr_en and b_valid can never overlap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            reg_wr_en    <= 1'b0;
            b_valid      <= 1'b0;
            b_resp       <= RESP_OKAY;
            reg_wr_index <= '0;
            reg_wr_data  <= '0;
            reg_wr_strb  <= '0;
        end else begin
            state_q   <= state_d;
            reg_wr_en <= (state_d == ST_WRITE);
            b_valid   <= (state_d == ST_RESP);

            if (accept) begin
                // Payload is captured only at the joint handshake, which
                // keeps it stable through any register-file or B stall.
                reg_wr_index <= dec_index;
                reg_wr_data  <= w_data;
                reg_wr_strb  <= w_strb;
                b_resp       <= dec_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (state_q == ST_WRITE && reg_wr_ready) begin
                b_resp <= RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_write_ctrl
//
// Directed bench for axi4lite_write_ctrl with default parameters
// (32-bit address and data, 16 registers). A vector table covers the
// single-transaction cases back to back; hand-written sequences cover skewed
// valids, backpressure on both output channels and reset mid-transaction.
// A negedge monitor compares every accepted register write with the queue
// of expected writes.
// -----------------------------------------------------------------------------
module tb_axi4lite_write_ctrl;

    localparam int W_ENTRY = 40; // {index[3:0], strb[3:0], data[31:0]}

    logic        clk;
    logic        resetn;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        reg_wr_en;
    logic        reg_wr_ready;
    logic [3:0]  reg_wr_index;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic [1:0]  dbg_state;

    int checks;
    int failures;
    int wr_count;
    int exp_writes;

    logic [W_ENTRY-1:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        exp_ok;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs[6];

    axi4lite_write_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .aw_valid     (aw_valid),
        .aw_ready     (aw_ready),
        .aw_addr      (aw_addr),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .w_strb       (w_strb),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_ready (reg_wr_ready),
        .reg_wr_index (reg_wr_index),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_strb  (reg_wr_strb),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_resp       (b_resp),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] idx, input logic [3:0] strb, input logic [31:0] data);
        exp_q.push_back({idx, strb, data});
        exp_writes++;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (resetn && reg_wr_en && reg_wr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write index=%0h data=%0h required=none",
                         reg_wr_index, reg_wr_data);
            end else begin
                chk("wr_payload", {24'd0, reg_wr_index, reg_wr_strb, reg_wr_data},
                    {24'd0, exp_q.pop_front()});
            end
            wr_count++;
        end
    end

    // One full transaction with both readies held at 1. Entered just after a
    // posedge with the DUT in IDLE; leaves just after the posedge that
    // returns it to IDLE, with the valids still asserted so the caller can
    // continue back to back.
    task automatic run_vec(input vec_t v);
        aw_valid = 1'b1;
        w_valid  = 1'b1;
        aw_addr  = v.addr;
        w_data   = v.data;
        w_strb   = v.strb;
        if (v.exp_ok) push_exp(v.exp_idx, v.strb, v.data);
        @(negedge clk);
        chk("hs_aw_ready", aw_ready, 1);
        chk("hs_w_ready", w_ready, 1);
        chk("hs_no_b_valid", b_valid, 0);
        tick();
        @(negedge clk);
        chk("busy_aw_ready", aw_ready, 0);
        if (v.exp_ok) begin
            chk("wr_en_n1", reg_wr_en, 1);
            chk("wr_index_n1", reg_wr_index, v.exp_idx);
            chk("wr_data_n1", reg_wr_data, v.data);
            chk("wr_strb_n1", reg_wr_strb, v.strb);
            chk("b_valid_n1", b_valid, 0);
            tick();
            @(negedge clk);
            chk("wr_en_n2", reg_wr_en, 0);
            chk("b_valid_n2", b_valid, 1);
            chk("b_resp_okay", b_resp, 2'b00);
            chk("resp_w_ready", w_ready, 0);
        end else begin
            chk("err_no_wr_en", reg_wr_en, 0);
            chk("err_b_valid", b_valid, 1);
            chk("err_b_resp", b_resp, 2'b10);
        end
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks       = 0;
        failures     = 0;
        wr_count     = 0;
        exp_writes   = 0;
        resetn       = 1'b0;
        aw_valid     = 1'b0;
        w_valid      = 1'b0;
        aw_addr      = '0;
        w_data       = '0;
        w_strb       = '0;
        reg_wr_ready = 1'b1;
        b_ready      = 1'b1;

        //            addr           data           strb   ok    idx
        vecs[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 1'b1, 4'd2};
        vecs[1] = '{32'h0000_0004, 32'h1234_5678, 4'h0, 1'b1, 4'd1};
        vecs[2] = '{32'h0000_0040, 32'h5555_AAAA, 4'hF, 1'b0, 4'd0};
        vecs[3] = '{32'h0000_003F, 32'hCAFE_0F0F, 4'h5, 1'b1, 4'd15};
        vecs[4] = '{32'h8000_0004, 32'h0000_0001, 4'h1, 1'b0, 4'd1};
        vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hA, 1'b1, 4'd0};

        // reset values
        #12;
        chk("rst_state", dbg_state, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_resp", b_resp, 0);
        chk("rst_payload", {reg_wr_index, reg_wr_strb, reg_wr_data}, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // idle with no valids: readies low
        @(negedge clk);
        chk("idle_aw_ready", aw_ready, 0);
        tick();

        // table of back-to-back transactions
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        @(negedge clk);
        chk("after_table_idle", dbg_state, 0);
        tick();

        // skewed valids: AW from cycle 0, W only at cycle 4
        begin
            int wr_before;
            wr_before = wr_count;
            aw_valid  = 1'b1;
            aw_addr   = 32'h0000_000C;
            w_data    = 32'hA5A5_0001;
            w_strb    = 4'h3;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk("skew_aw_ready", aw_ready, 0);
                chk("skew_w_ready", w_ready, 0);
                tick();
            end
            w_valid = 1'b1;
            push_exp(4'd3, 4'h3, 32'hA5A5_0001);
            @(negedge clk);
            chk("skew_join_aw", aw_ready, 1);
            chk("skew_join_w", w_ready, 1);
            tick();
            aw_valid = 1'b0;
            w_valid  = 1'b0;
            @(negedge clk);
            chk("skew_wr_en", reg_wr_en, 1);
            tick();
            @(negedge clk);
            chk("skew_b_valid", b_valid, 1);
            tick();
            @(negedge clk);
            chk("skew_one_write", wr_count - wr_before, 1);
            chk("skew_idle", dbg_state, 0);
            tick();
        end

        // backpressure: register file stalls 5 cycles, then B stalls 3
        reg_wr_ready = 1'b0;
        aw_valid     = 1'b1;
        w_valid      = 1'b1;
        aw_addr      = 32'h0000_0014;
        w_data       = 32'h0BAD_F00D;
        w_strb       = 4'hC;
        push_exp(4'd5, 4'hC, 32'h0BAD_F00D);
        @(negedge clk);
        chk("bp_hs", aw_ready, 1);
        tick();
        // a second request waits throughout and must not be taken
        aw_addr = 32'h0000_0018;
        w_data  = 32'h1111_2222;
        w_strb  = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_wr_en", reg_wr_en, 1);
            chk("bp_index", reg_wr_index, 4'd5);
            chk("bp_data", reg_wr_data, 32'h0BAD_F00D);
            chk("bp_wr_aw_ready", aw_ready, 0);
            chk("bp_wr_b_valid", b_valid, 0);
            tick();
        end
        reg_wr_ready = 1'b1;
        b_ready      = 1'b0;
        @(negedge clk);
        chk("bp_wr_release", reg_wr_en, 1);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_b_valid", b_valid, 1);
            chk("bp_b_resp", b_resp, 2'b00);
            chk("bp_b_wr_en", reg_wr_en, 0);
            chk("bp_b_aw_ready", aw_ready, 0);
            tick();
        end
        b_ready  = 1'b1;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        @(negedge clk);
        chk("bp_b_release", b_valid, 1);
        tick();
        @(negedge clk);
        chk("bp_done_idle", dbg_state, 0);
        chk("bp_done_b_valid", b_valid, 0);
        tick();

        // reset while in WRITE: transaction is dropped
        reg_wr_ready = 1'b0;
        aw_valid     = 1'b1;
        w_valid      = 1'b1;
        aw_addr      = 32'h0000_001C;
        w_data       = 32'h7777_8888;
        w_strb       = 4'hF;
        tick();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        @(negedge clk);
        chk("rstmid_in_write", dbg_state, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstmid_wr_en", reg_wr_en, 0);
        chk("rstmid_b_valid", b_valid, 0);
        chk("rstmid_state", dbg_state, 0);
        chk("rstmid_payload", {reg_wr_index, reg_wr_strb, reg_wr_data, b_resp}, 0);
        reg_wr_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {dbg_state, reg_wr_en, b_valid}, 0);
        end

        // final scoreboard state
        chk("exp_q_empty", exp_q.size(), 0);
        chk("total_writes", wr_count, exp_writes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4lite_write_ctrl.md
Name: axi4lite_write_ctrl

Overview:
- AXI4-Lite slave write-path controller, directly downstream of the AW and W skid buffers in the generated IP.
- Joins one AW beat and one W beat into a single register-file write, then returns a B response.
- Issues one transaction at a time; address decode selects a register index or flags SLVERR.

Parameters:
- ADDR_WIDTH, 32, width of aw_addr.
- DATA_WIDTH, 32, width of w_data and reg_wr_data; must be 32 or 64.
- NUM_REGS, 16, number of implemented registers; must be ≥2.
- IDX_WIDTH, $clog2(NUM_REGS), width of reg_wr_index (derived; do not override).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- resetn  in  1  asynchronous reset, active-low.
- aw_valid  in  1  write-address valid, from the AW skid buffer.
- aw_ready  out  1  write-address ready.
- aw_addr  in  ADDR_WIDTH  byte address.
- w_valid  in  1  write-data valid, from the W skid buffer.
- w_ready  out  1  write-data ready.
- w_data  in  DATA_WIDTH  write data.
- w_strb  in  DATA_WIDTH/8  byte strobes.
- reg_wr_en  out  1  register-file write request.
- reg_wr_ready  in  1  register file accepts the write this cycle.
- reg_wr_index  out  IDX_WIDTH  register index.
- reg_wr_data  out  DATA_WIDTH  latched write data.
- reg_wr_strb  out  DATA_WIDTH/8  latched strobes.
- b_valid  out  1  write-response valid.
- b_ready  in  1  write-response ready.
- b_resp  out  2  00 = OKAY, 10 = SLVERR.

Behaviour:
- Reset (resetn=0, async): state=IDLE; aw_ready, w_ready, reg_wr_en and b_valid are 0; b_resp, reg_wr_index, reg_wr_data and reg_wr_strb are 0.
- Reset asserted mid-transaction abandons it. No register write and no B response is issued for it.
- ADDR_LSB = log2(DATA_WIDTH/8). word = aw_addr >> ADDR_LSB. Low ADDR_LSB address bits are ignored (no alignment error).
- IDLE state:
  - aw_ready = w_ready = aw_valid & w_valid (combinational join).
  - Both channels handshake in the same cycle; never accept one without the other.
  - On handshake, latch reg_wr_index = word[IDX_WIDTH-1:0], w_data and w_strb.
  - If word < NUM_REGS → WRITE.
  - If word ≥ NUM_REGS (upper bits nonzero, or index ≥ NUM_REGS) → RESP with b_resp=SLVERR. No reg_wr_en is issued.
- WRITE state:
  - reg_wr_en=1; index, data and strb held stable.
  - Stay in WRITE while reg_wr_ready=0.
  - When reg_wr_en & reg_wr_ready → RESP, b_resp=OKAY.
- RESP state:
  - b_valid=1; b_resp held stable until b_ready.
  - On b_valid & b_ready → IDLE.
  - aw_ready and w_ready stay 0 in WRITE and RESP.
- Latency with reg_wr_ready and b_ready tied 1:
  - Handshake at cycle N, reg_wr_en at N+1, b_valid at N+2, IDLE at N+3.
  - Sustained throughput is 1 write per 3 cycles.
- w_strb=0 still issues reg_wr_en with strb 0 and responds OKAY.
- Registered outputs: reg_wr_en, reg_wr_index, reg_wr_data, reg_wr_strb, b_valid and b_resp are all flops. aw_ready and w_ready are combinational from state and valids.
- reg_wr_en and b_valid are never asserted in the same cycle.

Decomposition:
- Shared header axi4lite_defs.vh holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - State encodings ST_IDLE, ST_WRITE, ST_RESP.
  - The ADDR_LSB function of DATA_WIDTH, reused by the read-path controller.
- One sub-module, axi4lite_addr_decode: combinational aw_addr → {index, in_range}, parameterised identically. The read path reuses it.

Test Plan:
- Back-to-back write: aw_addr=0x08, w_data=0xDEADBEEF, strb=0xF, all readies 1 → reg_wr_en one cycle later with index=2, data=0xDEADBEEF; b_valid next cycle with b_resp=00; aw_ready=1 again 3 cycles after the first handshake.
- Skewed valids: aw_valid at cycle 0, w_valid at cycle 4 (aw held) → aw_ready and w_ready both stay 0 until cycle 4, then rise together; exactly one write issued.
- Out-of-range address: NUM_REGS=16, aw_addr=0x40 → no reg_wr_en pulse; b_valid with b_resp=10 on the cycle after the handshake.
- Backpressure: reg_wr_ready=0 for 5 cycles, then b_ready=0 for 3 cycles → reg_wr_en held with stable index/data for 5 cycles; b_valid and b_resp stable for 3 cycles; no new AW/W accepted throughout.
- Reset mid-op: resetn pulled low while in WRITE → all outputs 0 immediately (async); after release, state is IDLE and no b_valid appears.
- Zero strobe: w_strb=0, aw_addr=0x04 → reg_wr_en with index=1, strb=0; b_resp=00.
